// File: rtl/axi4lite_pid_regs.sv
// AXI4-Lite responder holding the PID coefficient/setpoint registers.
// Registers are exposed flat on reg_out, with a one-cycle wr_pulse per register
// following each committed write. Write and read channels run independent FSMs.
// Optional build macro PID_REGS_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY (timing and data behaviour are otherwise identical).
module axi4lite_pid_regs #(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH = 5,
    parameter int unsigned C_NUM_REGS   = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [C_ADDR_WIDTH-1:0]            AWADDR,
    input  logic [2:0]                         AWPROT,
    input  logic                               AWVALID,
    output logic                               AWREADY,
    input  logic [C_DATA_WIDTH-1:0]            WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]          WSTRB,
    input  logic                               WVALID,
    output logic                               WREADY,
    output logic [1:0]                         BRESP,
    output logic                               BVALID,
    input  logic                               BREADY,
    input  logic [C_ADDR_WIDTH-1:0]            ARADDR,
    input  logic [2:0]                         ARPROT,
    input  logic                               ARVALID,
    output logic                               ARREADY,
    output logic [C_DATA_WIDTH-1:0]            RDATA,
    output logic [1:0]                         RRESP,
    output logic                               RVALID,
    input  logic                               RREADY,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]              wr_pulse
);

    localparam int unsigned IdxW   = C_ADDR_WIDTH - 2;
    localparam int unsigned NBytes = C_DATA_WIDTH / 8;

    localparam logic [1:0] RespOkay = 2'b00;
`ifdef PID_REGS_SLVERR_EN
    localparam logic [1:0] RespOor  = 2'b10;
`else
    localparam logic [1:0] RespOor  = 2'b00;
`endif

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    w_state_e w_state_q;
    r_state_e r_state_q;

    logic                        aw_held_q;
    logic [IdxW-1:0]             aw_idx_q;
    logic                        w_held_q;
    logic [C_DATA_WIDTH-1:0]     w_data_q;
    logic [NBytes-1:0]           w_strb_q;
    logic [C_NUM_REGS*C_DATA_WIDTH-1:0] regs_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    commit;
    logic [IdxW-1:0]         wr_idx;
    logic [C_DATA_WIDTH-1:0] wr_data;
    logic [NBytes-1:0]       wr_strb;
    logic [C_NUM_REGS-1:0]   wr_sel;
    logic                    wr_hit;
    logic                    rd_hit;
    logic [C_DATA_WIDTH-1:0] rd_word;

    // Protection bits and byte-lane address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    assign reg_out = regs_q;

    // Write-side merge: a held beat takes priority over the live channel.
    always_comb begin
        aw_hs   = AWVALID & AWREADY;
        w_hs    = WVALID & WREADY;
        commit  = (w_state_q == WIdle) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
        wr_idx  = aw_held_q ? aw_idx_q : AWADDR[C_ADDR_WIDTH-1:2];
        wr_data = w_held_q ? w_data_q : WDATA;
        wr_strb = w_held_q ? w_strb_q : WSTRB;
        wr_sel  = '0;
        for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
            if (32'(wr_idx) == k) begin
                wr_sel[k] = 1'b1;
            end
        end
        wr_hit = |wr_sel;
    end

    // Read-side decode of the live AR address against the current register values.
    always_comb begin
        ar_hs   = ARVALID & ARREADY;
        rd_hit  = 1'b0;
        rd_word = '0;
        for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
            if (32'(ARADDR[C_ADDR_WIDTH-1:2]) == k) begin
                rd_hit  = 1'b1;
                rd_word = regs_q[C_DATA_WIDTH*k +: C_DATA_WIDTH];
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit once both are present, then hold B.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= WIdle;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b1;
            BVALID    <= 1'b0;
            BRESP     <= RespOkay;
            regs_q    <= '0;
            wr_pulse  <= '0;
        end else begin
            wr_pulse <= '0;
            case (w_state_q)
                WIdle: begin
                    if (commit) begin
                        for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
                            for (int unsigned b = 0; b < NBytes; b++) begin
                                if (wr_sel[k] && wr_strb[b]) begin
                                    regs_q[C_DATA_WIDTH*k+8*b +: 8] <= wr_data[8*b +: 8];
                                end
                            end
                        end
                        wr_pulse  <= wr_sel;
                        BVALID    <= 1'b1;
                        BRESP     <= wr_hit ? RespOkay : RespOor;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        AWREADY   <= 1'b0;
                        WREADY    <= 1'b0;
                        w_state_q <= WResp;
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            aw_idx_q  <= AWADDR[C_ADDR_WIDTH-1:2];
                            AWREADY   <= 1'b0;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            w_data_q <= WDATA;
                            w_strb_q <= WSTRB;
                            WREADY   <= 1'b0;
                        end
                    end
                end
                WResp: begin
                    if (BVALID && BREADY) begin
                        BVALID    <= 1'b0;
                        BRESP     <= RespOkay;
                        AWREADY   <= 1'b1;
                        WREADY    <= 1'b1;
                        w_state_q <= WIdle;
                    end
                end
                default: w_state_q <= WIdle;
            endcase
        end
    end

    // Read FSM: capture data on the AR handshake and hold it until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= RIdle;
            ARREADY   <= 1'b1;
            RVALID    <= 1'b0;
            RDATA     <= '0;
            RRESP     <= RespOkay;
        end else begin
            case (r_state_q)
                RIdle: begin
                    if (ar_hs) begin
                        RDATA     <= rd_word;
                        RRESP     <= rd_hit ? RespOkay : RespOor;
                        RVALID    <= 1'b1;
                        ARREADY   <= 1'b0;
                        r_state_q <= RData;
                    end
                end
                RData: begin
                    if (RVALID && RREADY) begin
                        RVALID    <= 1'b0;
                        RDATA     <= '0;
                        RRESP     <= RespOkay;
                        ARREADY   <= 1'b1;
                        r_state_q <= RIdle;
                    end
                end
                default: r_state_q <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_pid_regs.sv
// Directed bench for axi4lite_pid_regs. Inputs change and outputs are sampled on the
// falling edge of ACLK, so every observation reflects the state after the prior rising edge.
module tb_axi4lite_pid_regs;

    logic         ACLK;
    logic         ARESET;
    logic [4:0]   AWADDR;
    logic [2:0]   AWPROT;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [4:0]   ARADDR;
    logic [2:0]   ARPROT;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

`ifdef PID_REGS_SLVERR_EN
    localparam logic [1:0] OorResp = 2'b10;
`else
    localparam logic [1:0] OorResp = 2'b00;
`endif

    int n_vec  = 0;
    int n_miss = 0;
    int pulse_cnt [4] = '{default: 0};

    axi4lite_pid_regs dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    always @(negedge ACLK) begin
        for (int k = 0; k < 4; k++) begin
            if (wr_pulse[k] === 1'b1) pulse_cnt[k] = pulse_cnt[k] + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        bit aw_done, w_done;
        @(negedge ACLK);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b1;
        n = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && n < 20) begin
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            @(negedge ACLK);
            n++;
            if (aw_done) AWVALID = 1'b0;
            if (w_done) WVALID = 1'b0;
        end
        while (!BVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("wr_timeout", 128'(n < 20), 128'(1));
        resp = BRESP;
        @(negedge ACLK);
        BREADY = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1; RREADY = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        ARVALID = 1'b0;
        while (!RVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("rd_timeout", 128'(n < 20), 128'(1));
        d = RDATA;
        resp = RRESP;
        @(negedge ACLK);
        RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          psum;

        ARESET = 1'b1;
        AWADDR = '0; AWPROT = 3'b010; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARPROT = 3'b101; ARVALID = 1'b0; RREADY = 1'b0;

        // Reset state
        repeat (2) @(negedge ACLK);
        check("rst_awready", AWREADY, 1'b1);
        check("rst_wready", WREADY, 1'b1);
        check("rst_arready", ARREADY, 1'b1);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rdata", RDATA, 32'h0);
        check("rst_reg_out", reg_out, 128'h0);
        check("rst_wr_pulse", wr_pulse, 4'h0);
        ARESET = 1'b0;

        // First write with explicit latency: AW+W together, B and reg update next cycle
        @(negedge ACLK);
        AWADDR = 5'h00; AWVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        check("lat_bvalid", BVALID, 1'b1);
        check("lat_bresp", BRESP, 2'b00);
        check("lat_reg0", reg_out[31:0], 32'h1);
        check("lat_pulse", wr_pulse, 4'b0001);
        check("lat_awready", AWREADY, 1'b0);
        check("lat_wready", WREADY, 1'b0);
        AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        @(negedge ACLK);
        check("lat_b_done", BVALID, 1'b0);
        check("lat_pulse_off", wr_pulse, 4'b0000);
        check("lat_awready_back", AWREADY, 1'b1);
        BREADY = 1'b0;

        // Sequential programming of the remaining registers
        do_write(5'h04, 32'h2, 4'hF, rs);
        check("seq_bresp1", rs, 2'b00);
        do_write(5'h08, 32'h3, 4'hF, rs);
        check("seq_bresp2", rs, 2'b00);
        do_write(5'h0C, 32'h4, 4'hF, rs);
        check("seq_bresp3", rs, 2'b00);
        check("seq_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("seq_pulse%0d", k), 128'(pulse_cnt[k]), 128'(1));
        end
        for (int k = 0; k < 4; k++) begin
            do_read(5'(4 * k), rd, rs);
            check($sformatf("seq_rd%0d", k), rd, 32'(k + 1));
            check($sformatf("seq_rresp%0d", k), rs, 2'b00);
        end

        // AW three cycles ahead of W
        @(negedge ACLK);
        AWADDR = 5'h08; AWVALID = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        check("awfirst_awready", AWREADY, 1'b0);
        check("awfirst_wready", WREADY, 1'b1);
        AWVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        check("awfirst_no_b", BVALID, 1'b0);
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1;
        @(negedge ACLK);
        check("awfirst_bvalid", BVALID, 1'b1);
        check("awfirst_reg2", reg_out[95:64], 32'hDEADBEEF);
        check("awfirst_pulse", wr_pulse, 4'b0100);
        WVALID = 1'b0;
        @(negedge ACLK);
        check("awfirst_b_done", BVALID, 1'b0);
        BREADY = 1'b0;

        // W three cycles ahead of AW
        do_write(5'h08, 32'h0, 4'hF, rs);
        check("wfirst_clear", reg_out[95:64], 32'h0);
        @(negedge ACLK);
        WDATA = 32'hDEADBEEF; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b1;
        @(negedge ACLK);
        check("wfirst_wready", WREADY, 1'b0);
        check("wfirst_awready", AWREADY, 1'b1);
        WVALID = 1'b0;
        repeat (2) @(negedge ACLK);
        check("wfirst_no_b", BVALID, 1'b0);
        AWADDR = 5'h08; AWVALID = 1'b1;
        @(negedge ACLK);
        check("wfirst_bvalid", BVALID, 1'b1);
        check("wfirst_reg2", reg_out[95:64], 32'hDEADBEEF);
        AWVALID = 1'b0;
        @(negedge ACLK);
        check("wfirst_b_done", BVALID, 1'b0);
        BREADY = 1'b0;

        // Byte strobes with B backpressure
        do_write(5'h00, 32'hFFFFFFFF, 4'hF, rs);
        @(negedge ACLK);
        AWADDR = 5'h00; AWVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'b0101; WVALID = 1'b1;
        BREADY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            AWVALID = 1'b0; WVALID = 1'b0;
            check($sformatf("bp_bvalid%0d", i), BVALID, 1'b1);
            check($sformatf("bp_ready%0d", i), {AWREADY, WREADY}, 2'b00);
        end
        check("strb_reg0", reg_out[31:0], 32'hFF34FF78);
        BREADY = 1'b1;
        @(negedge ACLK);
        check("bp_b_done", BVALID, 1'b0);
        check("bp_ready_back", {AWREADY, WREADY}, 2'b11);
        BREADY = 1'b0;

        // Read stall while the same register is written on the AR edge
        @(negedge ACLK);
        ARADDR = 5'h04; ARVALID = 1'b1; RREADY = 1'b0;
        AWADDR = 5'h04; AWVALID = 1'b1; WDATA = 32'hAAAA5555; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            ARVALID = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
            check($sformatf("stall_rvalid%0d", i), RVALID, 1'b1);
            check($sformatf("stall_rdata%0d", i), RDATA, 32'h2);
        end
        check("stall_arready", ARREADY, 1'b0);
        check("stall_reg1", reg_out[63:32], 32'hAAAA5555);
        RREADY = 1'b1;
        @(negedge ACLK);
        check("stall_r_done", RVALID, 1'b0);
        check("stall_rdata_zero", RDATA, 32'h0);
        check("stall_arready_back", ARREADY, 1'b1);
        RREADY = 1'b0; BREADY = 1'b0;
        do_read(5'h04, rd, rs);
        check("stall_reread", rd, 32'hAAAA5555);

        // Out-of-range write and reads
        psum = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3];
        do_write(5'h10, 32'h99, 4'hF, rs);
        check("oor_bresp", rs, OorResp);
        check("oor_regs", reg_out, 128'h00000004_DEADBEEF_AAAA5555_FF34FF78);
        check("oor_no_pulse", 128'(pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]),
              128'(psum));
        do_read(5'h10, rd, rs);
        check("oor_rdata", rd, 32'h0);
        check("oor_rresp", rs, OorResp);
        do_read(5'h1C, rd, rs);
        check("oor_rdata_top", rd, 32'h0);
        do_read(5'h0E, rd, rs);
        check("lowbits_ignored", rd, 32'h4);

        // Reset on the commit edge aborts the write
        @(negedge ACLK);
        AWADDR = 5'h00; AWVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF; WVALID = 1'b1;
        BREADY = 1'b1; ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0; AWVALID = 1'b0; WVALID = 1'b0;
        check("mid_rst_bvalid", BVALID, 1'b0);
        check("mid_rst_regs", reg_out, 128'h0);
        check("mid_rst_pulse", wr_pulse, 4'h0);
        check("mid_rst_awready", AWREADY, 1'b1);
        repeat (3) @(negedge ACLK);
        check("mid_rst_no_b", BVALID, 1'b0);
        BREADY = 1'b0;
        do_write(5'h00, 32'h5, 4'hF, rs);
        check("post_rst_bresp", rs, 2'b00);
        check("post_rst_reg0", reg_out[31:0], 32'h5);
        do_read(5'h00, rd, rs);
        check("post_rst_rd", rd, 32'h5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
